mc_control_unit: RTL and testbench

- Multicycle Moore control FSM for the 32-bit MIPS-subset datapath.
- Sequences fetch, decode, execute, memory and writeback phases.
- Drives every datapath select, including the 2-bit write-register select of the destination-register mux, plus all write enables.
- Sits between the instruction register (opcode/funct) and the ALU, register file, memory, PC and EPC.

---
 rtl/mc_control_unit.sv | 129 ++++++++++++
 tb/tb_mc_control_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle Moore control FSM for the MIPS-subset datapath
module mc_control_unit #(
    parameter logic [31:0] SP_INIT        = 32'd227,
    parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11
)(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       Overflow,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemWR,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] WriteReg,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       EPCWrite,
    output logic [1:0] ExcCause,
    output logic [4:0] state_out
);
    typedef enum logic [4:0] {
        RST, FETCH0, FETCH1, DECODE, R_EXEC, R_WB, I_EXEC, I_WB, ADDR,
        MEM_RD, MEM_WAIT, LW_WB, MEM_WR, BEQ, JAL_WB, JUMP, EXC_OP, EXC_OVF
    } state_t;
    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       memwr;
        logic       irw;
        logic       regw;
        logic [1:0] wreg;
        logic [1:0] m2r;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
        logic       epcw;
    } ctrl_t;
    state_t     r_state, w_next;
    ctrl_t      r_ctrl;
    logic [1:0] r_exc;
    logic       w_rfn, w_unused;
    assign w_unused = Zero ^ (^SP_INIT);
    assign w_rfn = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24);
    // Outputs are registered from the next state, so they always match r_state.
    function automatic ctrl_t ctrl_of(input state_t s, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (s)
            RST:      begin c.regw = 1'b1; c.wreg = 2'b11; c.m2r = 2'b11; end
            FETCH1:   begin c.irw = 1'b1; c.srcb = 2'b01; c.aluop = 3'b001; c.pcw = 1'b1; end
            DECODE:   begin c.srcb = 2'b11; c.aluop = 3'b001; end
            R_EXEC:   begin c.srca = 1'b1; c.aluop = (f == 6'h22) ? 3'b010 : (f == 6'h24) ? 3'b011 : 3'b001; end
            R_WB:     c.regw = 1'b1;
            I_EXEC:   begin c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 3'b001; end
            I_WB:     begin c.regw = 1'b1; c.wreg = 2'b01; end
            ADDR:     begin c.srca = 1'b1; c.srcb = 2'b10; c.aluop = 3'b001; end
            MEM_RD:   c.iord = 1'b1;
            MEM_WAIT: c.iord = 1'b1;
            LW_WB:    begin c.regw = 1'b1; c.wreg = 2'b01; c.m2r = 2'b01; end
            MEM_WR:   begin c.iord = 1'b1; c.memwr = 1'b1; end
            BEQ:      begin c.srca = 1'b1; c.aluop = 3'b010; c.pcsrc = 2'b01; c.pcwc = 1'b1; end
            JAL_WB:   begin c.regw = 1'b1; c.wreg = 2'b10; c.m2r = 2'b10; end
            JUMP:     begin c.pcsrc = 2'b10; c.pcw = 1'b1; end
            EXC_OP,
            EXC_OVF:  begin c.epcw = 1'b1; c.pcsrc = EXC_VECTOR_SEL; c.pcw = 1'b1; end
            default:  ;
        endcase
        return c;
    endfunction
    always_comb begin
        w_next = FETCH0;
        case (r_state)
            RST:      w_next = FETCH0;
            FETCH0:   w_next = FETCH1;
            FETCH1:   w_next = DECODE;
            DECODE:   w_next = (opcode == 6'h00) ? (w_rfn ? R_EXEC : EXC_OP) :
                               (opcode == 6'h08) ? I_EXEC :
                               (opcode == 6'h23 || opcode == 6'h2B) ? ADDR :
                               (opcode == 6'h04) ? BEQ :
                               (opcode == 6'h02) ? JUMP :
                               (opcode == 6'h03) ? JAL_WB : EXC_OP;
            R_EXEC:   w_next = (funct != 6'h24 && Overflow) ? EXC_OVF : R_WB;
            I_EXEC:   w_next = Overflow ? EXC_OVF : I_WB;
            ADDR:     w_next = (opcode == 6'h2B) ? MEM_WR : MEM_RD;
            MEM_RD:   w_next = MEM_WAIT;
            MEM_WAIT: w_next = LW_WB;
            JAL_WB:   w_next = JUMP;
            default:  w_next = FETCH0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RST;
            r_ctrl  <= ctrl_of(RST, funct);
            r_exc   <= 2'b00;
        end else begin
            r_state <= w_next;
            r_ctrl  <= ctrl_of(w_next, funct);
            if (r_state == EXC_OP)
                r_exc <= 2'b01;
            else if (r_state == EXC_OVF)
                r_exc <= 2'b10;
        end
    end
    assign PCWrite     = r_ctrl.pcw;
    assign PCWriteCond = r_ctrl.pcwc;
    assign IorD        = r_ctrl.iord;
    assign MemWR       = r_ctrl.memwr;
    assign IRWrite     = r_ctrl.irw;
    assign RegWrite    = r_ctrl.regw;
    assign WriteReg    = r_ctrl.wreg;
    assign MemtoReg    = r_ctrl.m2r;
    assign ALUSrcA     = r_ctrl.srca;
    assign ALUSrcB     = r_ctrl.srcb;
    assign ALUOp       = r_ctrl.aluop;
    assign PCSource    = r_ctrl.pcsrc;
    assign EPCWrite    = r_ctrl.epcw;
    assign ExcCause    = r_exc;
    assign state_out   = r_state;
endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: scoreboard bench for the multicycle control FSM
module tb_mc_control_unit;
    localparam int S_RST = 0, S_F0 = 1, S_F1 = 2, S_DEC = 3, S_REX = 4, S_RWB = 5,
                   S_IEX = 6, S_IWB = 7, S_ADDR = 8, S_MRD = 9, S_MWT = 10, S_LWB = 11,
                   S_MWR = 12, S_BEQ = 13, S_JALWB = 14, S_JUMP = 15, S_EXOP = 16, S_EXOVF = 17;
    logic       clk, reset, Zero, Overflow;
    logic [5:0] opcode, funct;
    logic       PCWrite, PCWriteCond, IorD, MemWR, IRWrite, RegWrite, ALUSrcA, EPCWrite;
    logic [1:0] WriteReg, MemtoReg, ALUSrcB, PCSource, ExcCause;
    logic [2:0] ALUOp;
    logic [4:0] state_out;
    typedef struct packed {
        logic [25:0] vec;
        logic [4:0]  st;
    } exp_t;
    exp_t       q[$];
    int         n_cmp = 0, n_bad = 0, n_cyc = 0;
    logic [1:0] exp_exc = 2'b00;

    mc_control_unit dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero),
        .Overflow(Overflow), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemWR(MemWR), .IRWrite(IRWrite), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .EPCWrite(EPCWrite), .ExcCause(ExcCause), .state_out(state_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [25:0] ev(input int s, input logic [2:0] aop);
        logic pcw, pcwc, iord, mw, irw, rw, sa, ep;
        logic [1:0] wr, m2r, sb, ps;
        logic [2:0] op;
        {pcw, pcwc, iord, mw, irw, rw, sa, ep} = '0;
        {wr, m2r, sb, ps} = '0;
        op = 3'b000;
        case (s)
            S_RST:   begin rw = 1; wr = 2'b11; m2r = 2'b11; end
            S_F1:    begin irw = 1; sb = 2'b01; op = 3'b001; pcw = 1; end
            S_DEC:   begin sb = 2'b11; op = 3'b001; end
            S_REX:   begin sa = 1; op = aop; end
            S_RWB:   rw = 1;
            S_IEX, S_ADDR: begin sa = 1; sb = 2'b10; op = 3'b001; end
            S_IWB:   begin rw = 1; wr = 2'b01; end
            S_MRD, S_MWT: iord = 1;
            S_LWB:   begin rw = 1; wr = 2'b01; m2r = 2'b01; end
            S_MWR:   begin iord = 1; mw = 1; end
            S_BEQ:   begin sa = 1; op = 3'b010; ps = 2'b01; pcwc = 1; end
            S_JALWB: begin rw = 1; wr = 2'b10; m2r = 2'b10; end
            S_JUMP:  begin ps = 2'b10; pcw = 1; end
            S_EXOP, S_EXOVF: begin ep = 1; ps = 2'b11; pcw = 1; end
            default: ;
        endcase
        return {5'(s), pcw, pcwc, iord, mw, irw, rw, wr, m2r, sa, sb, op, ps, ep, exp_exc};
    endfunction

    task automatic cyc(input int s, input logic [2:0] aop = 3'b000);
        @(posedge clk);
        #1;
        q.push_back('{vec: ev(s, aop), st: 5'(s)});
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
        opcode = op;
        funct = fn;
        Overflow = ovf;
        cyc(S_F0);
        cyc(S_F1);
        cyc(S_DEC);
    endtask

    always @(negedge clk) begin
        logic [25:0] got;
        exp_t e;
        n_cyc++;
        got = {state_out, PCWrite, PCWriteCond, IorD, MemWR, IRWrite, RegWrite, WriteReg,
               MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, EPCWrite, ExcCause};
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if (got !== e.vec) begin
                n_bad++;
                $display("FAIL cyc%0d state%0d: got %h expected %h", n_cyc, e.st, got, e.vec);
            end
        end
    end

    initial begin
        reset = 1'b1;
        opcode = 6'h00;
        funct = 6'h00;
        Zero = 1'b0;
        Overflow = 1'b0;
        repeat (3) cyc(S_RST);
        reset = 1'b0;
        fetch(6'h00, 6'h20, 1'b0); cyc(S_REX, 3'b001); cyc(S_RWB);
        fetch(6'h00, 6'h22, 1'b1); cyc(S_REX, 3'b010); cyc(S_EXOVF);
        exp_exc = 2'b10;
        fetch(6'h00, 6'h24, 1'b1); cyc(S_REX, 3'b011); cyc(S_RWB);
        fetch(6'h23, 6'h00, 1'b1); cyc(S_ADDR); cyc(S_MRD); cyc(S_MWT); cyc(S_LWB);
        fetch(6'h2B, 6'h00, 1'b0); cyc(S_ADDR); cyc(S_MWR);
        fetch(6'h03, 6'h00, 1'b0); cyc(S_JALWB); cyc(S_JUMP);
        fetch(6'h04, 6'h00, 1'b0); cyc(S_BEQ);
        fetch(6'h02, 6'h00, 1'b0); cyc(S_JUMP);
        fetch(6'h08, 6'h00, 1'b0); cyc(S_IEX); cyc(S_IWB);
        fetch(6'h3F, 6'h00, 1'b0); cyc(S_EXOP);
        exp_exc = 2'b01;
        fetch(6'h08, 6'h00, 1'b1); cyc(S_IEX); cyc(S_EXOVF);
        exp_exc = 2'b10;
        fetch(6'h00, 6'h21, 1'b0); cyc(S_EXOP);
        exp_exc = 2'b01;
        fetch(6'h2B, 6'h00, 1'b0); cyc(S_ADDR); cyc(S_MWR);
        reset = 1'b1;
        exp_exc = 2'b00;
        cyc(S_RST);
        reset = 1'b0;
        fetch(6'h00, 6'h20, 1'b0); cyc(S_REX, 3'b001); cyc(S_RWB);
        reset = 1'b1;
        cyc(S_RST);
        reset = 1'b0;
        cyc(S_F0);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
